// File: rtl/fetch_queue_if.sv
// Instruction-memory port of the fetch stage: single-word reads, one outstanding at a time.
// Handshake: the fetch stage pulses imem_req_o for one cycle with imem_addr_o valid in that
// same cycle; the memory answers with a one-cycle imem_rvalid_i pulse (rdata valid with it) at
// least one cycle later. There is no ready/backpressure, so the requester must already have room
// for the word when it issues the request.
interface fetch_queue_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_queue.sv
// RV32I fetch stage: owns the PC, issues one imem read at a time and buffers returned
// words with their PCs in a small FIFO whose head feeds decode.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       stall_en,
  input  logic                       flush,
  input  logic [31:0]                flush_pc_i,
  fetch_queue_if.master              imem,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic [1:0]                 dbg_state_o,
  output logic [$clog2(DEPTH):0]     dbg_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   wpc_q  [DEPTH];

  logic          head_valid;
  logic          pop;
  logic          push;
  logic          space;
  logic          issue;
  logic [AW+1:0] fill_next;

  assign head_valid = (count_q != '0);
  assign pop        = !stall_en && !flush && head_valid;
  assign push       = (state_q == WAIT) && imem.imem_rvalid_i && !flush;
  assign fill_next  = {1'b0, count_q} + (AW+2)'(push) - (AW+2)'(pop);
  assign space      = fill_next < (AW+2)'(DEPTH);
  // Space is reserved at issue time, so a returning word can always be pushed.
  assign issue      = !flush && space &&
                      ((state_q == IDLE) || ((state_q == WAIT) && imem.imem_rvalid_i));

  assign imem.imem_req_o  = rstn_i && issue;
  assign imem.imem_addr_o = pc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid_i) state_d = issue ? WAIT : IDLE;
        else if (flush)         state_d = DROP;
      end
      DROP: begin
        // The in-flight word belongs to the squashed path; the next request leaves from IDLE.
        if (imem.imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        pc_q     <= flush_pc_i;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (issue) begin
          req_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
        end
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q[wr_ptr_q] <= imem.imem_rdata_i;
      wpc_q[wr_ptr_q]  <= req_pc_q;
    end
  end

  // An empty queue shows a bubble (instr 0) tagged with the next fetch address.
  assign instr_o     = head_valid ? word_q[rd_ptr_q] : 32'h0;
  assign pc_o        = head_valid ? wpc_q[rd_ptr_q]  : pc_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of decode.
- Owns the PC and issues single-word reads to the instruction memory. At most one request is outstanding at a time.
- Buffers returned words with their PCs in a small FIFO and presents the FIFO head to decode as instr/pc.
- Honours the hazard unit's stall_en and flush. A flush redirects the PC to a target, empties the FIFO and drops any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, FIFO entries (power of 2, >=2).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- stall_en  in  1  from hazard unit; decode is holding, so do not pop.
- flush  in  1  from hazard unit; redirect to flush_pc_i.
- flush_pc_i  in  32  redirect target (branch/jump resolved in execute).
- imem_req_o  out  1  one-cycle read request pulse.
- imem_addr_o  out  32  request address, always pc_q.
- imem_rvalid_i  in  1  response valid; arrives >=1 cycle after req.
- imem_rdata_i  in  32  response word.
- instr_o  out  32  to decode instr_i; FIFO head word, 32'b0 (bubble) when empty.
- pc_o  out  32  to decode pc_fetch; FIFO head PC, pc_q when empty.

Behaviour:
- Reset (rstn_i=0 at posedge):
  - pc_q<=RESET_PC, FIFO count<=0, state<=IDLE.
  - imem_req_o=0 while rstn_i=0.
  - instr_o=0, pc_o=RESET_PC.
  - Reset overrides flush, stall and rvalid. Imem shares rstn_i, so no stale response survives reset.
- State register: IDLE (no request outstanding), WAIT (request outstanding, data wanted), DROP (request outstanding, data to be discarded).
- Per-cycle terms:
  - pop = !stall_en & !flush & count!=0
  - push = state==WAIT & imem_rvalid_i & !flush
  - space = (count + push - pop) < DEPTH
  - issue = !flush & space & (state==IDLE | (state==WAIT & imem_rvalid_i))
  - imem_req_o = issue (combinational); imem_addr_o = pc_q at issue. For a same-cycle rvalid+issue in WAIT, the address is the already-incremented next PC (pc_q tracks the next fetch address; each request's PC is captured into req_pc_q at issue).
- Transitions:
  - IDLE: issue -> WAIT, req_pc_q<=pc_q, pc_q<=pc_q+4.
  - WAIT, rvalid, no flush: push {req_pc_q, rdata}. Then issue -> stay WAIT (back-to-back); else -> IDLE.
  - WAIT, no rvalid, no flush: hold.
  - WAIT, flush & !rvalid: -> DROP.
  - WAIT, flush & rvalid: response discarded, -> IDLE.
  - DROP, rvalid: discard, -> IDLE. No issue in that cycle; the next request goes out from IDLE.
  - DROP, no rvalid: hold.
- Flush in any state:
  - pc_q<=flush_pc_i, count/pointers<=0, no push, no pop, no issue that cycle.
  - A flush while in DROP updates pc_q again and stays in DROP.
- FIFO:
  - Circular, read/write pointers of log2(DEPTH) bits wrap naturally.
  - Simultaneous push+pop keeps count unchanged.
  - Outputs come combinationally from registered storage.
  - A push is never refused: issue reserves space.
- Stall: FIFO head holds stable on instr_o/pc_o. Fetching continues until the FIFO is full, then stops.
- Arithmetic: pc+4 is 32-bit modulo (0xFFFF_FFFC -> 0x0000_0000). flush_pc_i is used unaligned as given; alignment is checked upstream.
- Empty FIFO: instr_o=0, which decode treats as a bubble.

Test Plan:
- Reset release, memory returns rdata=0x00500093 one cycle after each req, no stall:
  - req at 0x0, then 0x4, 0x8…, one per cycle after the first response.
  - Decode sees pc 0x0/instr 0x00500093, then consecutive PCs with no gaps after the first fill.
- stall_en held 6 cycles with DEPTH=2:
  - FIFO fills to 2, imem_req_o stays 0.
  - instr_o/pc_o frozen on the same head.
  - On release, pops in order 0x8, 0xC with no loss or duplication.
- Flush while in WAIT, flush_pc_i=0x100, response 0xDEADBEEF arrives 2 cycles later:
  - The 0xDEADBEEF word is never presented.
  - Next req addr is 0x100; instr_o=0 until that response.
- Flush coincident with rvalid:
  - Word dropped, state IDLE, next cycle req at flush_pc_i.
- Back-to-back flushes (0x200 then 0x300) while in DROP:
  - The single pending response is discarded; first new req is at 0x300.
- rstn_i low for 1 cycle mid-stream, count=2:
  - count=0, instr_o=0, pc_o=RESET_PC.
  - Next req is at RESET_PC.
